score_bcd_display: RTL

//  Downstream consumer of jumplogic's Score[19:0]. Once per frame, converts the binary score to six BCD

---
 rtl/doodle_pkg.sv | 15 +
 rtl/score_bcd_display_bcd_add3.sv | 11 +
 rtl/score_bcd_display.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/doodle_pkg.sv
// Shared types and constants for the score display path.
package doodle_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    BCD_IDLE,
    BCD_LOAD,
    BCD_SHIFT,
    BCD_COMMIT
  } bcd_state_t;

  localparam logic [19:0] SCORE_SAT = 20'd999999;

endpackage

// File: rtl/score_bcd_display_bcd_add3.sv
// One double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3
  import doodle_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/score_bcd_display.sv
// Converts the binary score to BCD once per frame (rising frame_clk), tracks the
// session high score and drives registered display digits with leading-zero blanking.
module score_bcd_display
  import doodle_pkg::*;
#(
  parameter int                 SCORE_W    = 20,
  parameter int                 NUM_DIGITS = 6,
  parameter logic [SCORE_W-1:0] SAT_VALUE  = SCORE_W'(SCORE_SAT)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic [SCORE_W-1:0]      Score,
  input  logic                    show_high,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [4*NUM_DIGITS-1:0] hi_digits,
  output logic                    saturated,
  output logic                    busy,
  output logic                    done,
  output bcd_state_t              dbg_state
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SCORE_W - 1);

  bcd_state_t state_q, state_d;
  logic                  frame_clk_q;
  logic [SCORE_W-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sat_r_q, sat_r_d;
  logic [BCD_W-1:0]      cur_q, cur_d;
  logic [BCD_W-1:0]      hi_q, hi_d;
  logic                  sat_q, sat_d;
  logic                  done_q, done_d;
  logic [BCD_W-1:0]      digits_q, digits_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;

  logic                     start;
  logic                     zero_run;
  logic [BCD_W-1:0]         bcd_adj;
  logic [BCD_W+SCORE_W-1:0] shifted;

  assign start = frame_clk & ~frame_clk_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  assign shifted = {bcd_adj, bin_q} << 1;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sat_r_d = sat_r_q;
    cur_d   = cur_q;
    hi_d    = hi_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    case (state_q)
      BCD_IDLE: begin
        if (start) state_d = BCD_LOAD;
      end
      BCD_LOAD: begin
        sat_r_d = (Score > SAT_VALUE);
        bin_d   = (Score > SAT_VALUE) ? SAT_VALUE : Score;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = BCD_SHIFT;
      end
      BCD_SHIFT: begin
        bcd_d = shifted[BCD_W+SCORE_W-1:SCORE_W];
        bin_d = shifted[SCORE_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SHIFT) state_d = BCD_COMMIT;
      end
      BCD_COMMIT: begin
        cur_d  = bcd_q;
        sat_d  = sat_r_q;
        done_d = 1'b1;
        // Valid packed BCD orders the same as its raw bits, so a plain compare is digit-wise from the MSD.
        if (bcd_q > hi_q) hi_d = bcd_q;
        state_d = BCD_IDLE;
      end
      default: state_d = BCD_IDLE;
    endcase
  end

  // Mux the next-cycle values so committed digits appear together with done.
  always_comb begin
    digits_d = show_high ? hi_d : cur_d;
    blank_d  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (digits_d[4*i +: 4] == 4'd0);
      blank_d[i] = zero_run;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= BCD_IDLE;
      frame_clk_q <= 1'b0;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      sat_r_q     <= 1'b0;
      cur_q       <= '0;
      hi_q        <= '0;
      sat_q       <= 1'b0;
      done_q      <= 1'b0;
      digits_q    <= '0;
      blank_q     <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    end else begin
      state_q     <= state_d;
      frame_clk_q <= frame_clk;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      sat_r_q     <= sat_r_d;
      cur_q       <= cur_d;
      hi_q        <= hi_d;
      sat_q       <= sat_d;
      done_q      <= done_d;
      digits_q    <= digits_d;
      blank_q     <= blank_d;
    end
  end

  assign digits      = digits_q;
  assign digit_blank = blank_q;
  assign hi_digits   = hi_q;
  assign saturated   = sat_q;
  assign done        = done_q;
  assign busy        = (state_q != BCD_IDLE);
  assign dbg_state   = state_q;

endmodule
